// File: rtl/pt2262_pkg.sv
// Shared types, alpha-unit timing constants and the per-trit PWM shape
// for the PT2262-compatible encoder.
package pt2262_pkg;

    typedef enum logic [1:0] {T0, T1, TF} trit_t;
    typedef enum logic [1:0] {LOAD, DATA, SYNC} state_t;

    localparam int BIT_UNITS  = 32;
    localparam int SYNC_UNITS = 128;
    localparam int SHORT      = 4;
    localparam int LONG       = 12;
    localparam int WORD_BITS  = 12;
    localparam int UNIT_W     = 7;

    // Each bit is two half-bits of 16 units: a high pulse then low filler.
    // The first half is long only for '1'; the second half is short only for '0'.
    function automatic logic pulse_level(trit_t trit, logic [UNIT_W-1:0] unit_cnt);
        logic [UNIT_W-1:0] half_pos;
        int                high_units;
        if (unit_cnt < UNIT_W'(BIT_UNITS / 2)) begin
            half_pos   = unit_cnt;
            high_units = (trit == T1) ? LONG : SHORT;
        end else begin
            half_pos   = unit_cnt - UNIT_W'(BIT_UNITS / 2);
            high_units = (trit == T0) ? SHORT : LONG;
        end
        return half_pos < UNIT_W'(high_units);
    endfunction

endpackage

// File: rtl/pt2262_addr_decode.sv
// Splits the tri-state address pins into a binary value and a float mask.
module pt2262_addr_decode #(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] a,
    output logic [ADDR_W-1:0] a_01,
    output logic [ADDR_W-1:0] a_f
);

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_W; gi++) begin : g_trit
            // Anything that is not a clean 0 or 1 (Z or X) is coded as float.
            assign a_f[gi]  = (a[gi] !== 1'b0) && (a[gi] !== 1'b1);
            assign a_01[gi] = (a[gi] === 1'b1);
        end
    endgenerate

endmodule

// File: rtl/pt2262_encoder.sv
// PT2262-compatible encoder: 8 address trits, 4 data bits and a sync bit,
// sent back-to-back as PWM on cod_o with registered outputs.
module pt2262_encoder
    import pt2262_pkg::*;
#(
    parameter int ALPHA_CYCLES = 250,
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic              sync,
    output logic              cod_o
);

    localparam int WB = ADDR_W + DATA_W;
    localparam int AW = (ALPHA_CYCLES > 1) ? $clog2(ALPHA_CYCLES) : 1;
    localparam int BW = (WB > 1) ? $clog2(WB) : 1;
    localparam logic [AW-1:0]     ALPHA_LAST = AW'(ALPHA_CYCLES - 1);
    localparam logic [BW-1:0]     BIT_LAST   = BW'(WB - 1);
    localparam logic [UNIT_W-1:0] BIT_LAST_U  = UNIT_W'(BIT_UNITS - 1);
    localparam logic [UNIT_W-1:0] SYNC_LAST_U = UNIT_W'(SYNC_UNITS - 1);

    logic [ADDR_W-1:0] a_01;
    logic [ADDR_W-1:0] a_f;

    pt2262_addr_decode #(.ADDR_W(ADDR_W)) u_addr_decode (
        .a    (A),
        .a_01 (a_01),
        .a_f  (a_f)
    );

    state_t            state_reg, state_next;
    logic [AW-1:0]     alpha_reg, alpha_next;
    logic [UNIT_W-1:0] unit_reg, unit_next;
    logic [BW-1:0]     bit_reg, bit_next;
    logic [ADDR_W-1:0] a01_reg, a01_next;
    logic [ADDR_W-1:0] af_reg, af_next;
    logic [DATA_W-1:0] d_reg, d_next;
    logic              cod_reg, cod_next;
    logic              sync_reg, sync_next;
    logic              load;
    trit_t             trit_next;

    // Word order: A[0]..A[ADDR_W-1], then D from MSB down to LSB.
    function automatic trit_t sel_trit(int idx, logic [ADDR_W-1:0] a01,
                                       logic [ADDR_W-1:0] af, logic [DATA_W-1:0] d);
        trit_t t;
        t = T0;
        for (int i = 0; i < ADDR_W; i++)
            if (idx == i) t = af[i] ? TF : (a01[i] ? T1 : T0);
        for (int j = 0; j < DATA_W; j++)
            if (idx == ADDR_W + j) t = d[DATA_W-1-j] ? T1 : T0;
        return t;
    endfunction

    always_comb begin
        state_next = state_reg;
        alpha_next = alpha_reg;
        unit_next  = unit_reg;
        bit_next   = bit_reg;
        a01_next   = a01_reg;
        af_next    = af_reg;
        d_next     = d_reg;
        load       = 1'b0;

        case (state_reg)
            DATA: begin
                if (alpha_reg != ALPHA_LAST) begin
                    alpha_next = alpha_reg + 1'b1;
                end else begin
                    alpha_next = '0;
                    if (unit_reg != BIT_LAST_U) begin
                        unit_next = unit_reg + 1'b1;
                    end else begin
                        unit_next = '0;
                        if (bit_reg != BIT_LAST) begin
                            bit_next = bit_reg + 1'b1;
                        end else begin
                            bit_next   = '0;
                            state_next = SYNC;
                        end
                    end
                end
            end
            SYNC: begin
                if (alpha_reg != ALPHA_LAST) begin
                    alpha_next = alpha_reg + 1'b1;
                end else begin
                    alpha_next = '0;
                    if (unit_reg != SYNC_LAST_U) unit_next = unit_reg + 1'b1;
                    else                         load = 1'b1;
                end
            end
            default: load = 1'b1;
        endcase

        // Loading shares the edge that starts bit 0, so every word is exactly
        // 512 alpha long, including the first one after reset.
        if (load) begin
            state_next = DATA;
            alpha_next = '0;
            unit_next  = '0;
            bit_next   = '0;
            a01_next   = a_01;
            af_next    = a_f;
            d_next     = D;
        end

        trit_next = sel_trit(int'(bit_next), a01_next, af_next, d_next);
        sync_next = (state_next == SYNC);
        cod_next  = sync_next ? (unit_next < UNIT_W'(SHORT))
                              : pulse_level(trit_next, unit_next);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= LOAD;
            alpha_reg <= '0;
            unit_reg  <= '0;
            bit_reg   <= '0;
            a01_reg   <= '0;
            af_reg    <= '0;
            d_reg     <= '0;
            cod_reg   <= 1'b0;
            sync_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            alpha_reg <= alpha_next;
            unit_reg  <= unit_next;
            bit_reg   <= bit_next;
            a01_reg   <= a01_next;
            af_reg    <= af_next;
            d_reg     <= d_next;
            cod_reg   <= cod_next;
            sync_reg  <= sync_next;
        end
    end

    assign cod_o = cod_reg;
    assign sync  = sync_reg;

endmodule

// File: tb/tb_pt2262_encoder.sv
// Self-checking bench for pt2262_encoder with a 4-clock alpha unit.
module tb_pt2262_encoder;

    localparam int ALPHA      = 4;
    localparam int WORD_CLK   = 512 * ALPHA;
    localparam int SYNC_START = 384 * ALPHA;
    localparam int SEG_W [3][4] = '{'{4, 12, 4, 12}, '{12, 4, 12, 4}, '{4, 12, 12, 4}};

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] a_sig = 8'h00;
    logic [3:0] d_sig = 4'h0;
    logic       sync;
    logic       cod_o;

    always #5 clk = ~clk;

    pt2262_encoder #(.ALPHA_CYCLES(ALPHA), .ADDR_W(8), .DATA_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (a_sig),
        .D     (d_sig),
        .sync  (sync),
        .cod_o (cod_o)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    logic cap_cod  [WORD_CLK];
    logic cap_sync [WORD_CLK];
    int   abs_cyc   = 0;
    int   last_rise = -1;
    logic prev_sync = 1'b0;

    typedef struct {
        logic [7:0]  a_val;
        logic [7:0]  a_flt;
        logic [3:0]  d;
        int          chk_bit;
        logic [31:0] exp_w;
    } vec_t;
    vec_t vecs [7];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%08h) required %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] mk_a(logic [7:0] val, logic [7:0] flt);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = flt[i] ? 1'bz : val[i];
        return r;
    endfunction

    // 0 / 1 / F index into SEG_W, from the pin value as the bench drives it.
    function automatic int trit_of(logic [7:0] a, logic [3:0] d, int b);
        if (b < 8) begin
            if (a[b] === 1'b0) return 0;
            if (a[b] === 1'b1) return 1;
            return 2;
        end
        return d[11-b] ? 1 : 0;
    endfunction

    // Reference level at clock t of a word: walk the alternating H/L segments.
    function automatic logic model_cod(logic [7:0] a, logic [3:0] d, int t);
        int u, b, k, tr, edge_pos;
        u = t / ALPHA;
        b = u / 32;
        k = u % 32;
        if (b >= 12) return (u - 384) < 4;
        tr = trit_of(a, d, b);
        edge_pos = 0;
        for (int s = 0; s < 4; s++) begin
            edge_pos += SEG_W[tr][s];
            if (k < edge_pos) return (s % 2) == 0;
        end
        return 1'b0;
    endfunction

    task automatic capture_word(int change_at, logic [7:0] na, logic [3:0] nd);
        for (int t = 0; t < WORD_CLK; t++) begin
            @(negedge clk);
            cap_cod[t]  = cod_o;
            cap_sync[t] = sync;
            if (sync && !prev_sync) begin
                if (last_rise >= 0) check("sync_period", 32'(abs_cyc - last_rise), 32'(WORD_CLK));
                last_rise = abs_cyc;
            end
            prev_sync = sync;
            abs_cyc++;
            if (t == change_at) begin
                a_sig = na;
                d_sig = nd;
            end
        end
    endtask

    task automatic check_word(string name, logic [7:0] a, logic [3:0] d);
        int   bad   = 0;
        int   first = -1;
        logic e_cod, e_sync;
        for (int t = 0; t < WORD_CLK; t++) begin
            e_cod  = model_cod(a, d, t);
            e_sync = (t >= SYNC_START);
            if (cap_cod[t] !== e_cod || cap_sync[t] !== e_sync) begin
                bad++;
                if (first < 0) first = t;
            end
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s: %0d cycles differ from model, first at cycle %0d (cod=%b sync=%b, required cod=%b sync=%b)",
                     name, bad, first, cap_cod[first], cap_sync[first],
                     model_cod(a, d, first), first >= SYNC_START);
        end else begin
            $display("word %s a=%b d=%b matches model", name, a, d);
        end
    endtask

    // Run lengths of the four H/L segments of bit b, packed 8 bits each.
    function automatic logic [31:0] measure_bit(int b);
        int          p, stop, len;
        logic [31:0] res;
        p    = b * 32 * ALPHA;
        stop = p + 32 * ALPHA;
        res  = '0;
        for (int r = 0; r < 4; r++) begin
            len = 0;
            while (p < stop && cap_cod[p] === ((r % 2) == 0)) begin
                len++;
                p++;
            end
            res = {res[23:0], 8'(len)};
        end
        return res;
    endfunction

    function automatic logic [31:0] sync_stats();
        int sc = 0;
        int ch = 0;
        for (int t = 0; t < WORD_CLK; t++) begin
            if (cap_sync[t] === 1'b1) begin
                sc++;
                if (cap_cod[t] === 1'b1) ch++;
            end
        end
        return {16'(sc), 16'(ch)};
    endfunction

    task automatic do_reset(logic [7:0] a, logic [3:0] d);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        a_sig     = a;
        d_sig     = d;
        last_rise = -1;
        prev_sync = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0] cur_a, nxt_a;
        logic [3:0] cur_d, nxt_d;
        logic [31:0] w;

        vecs[0] = '{8'b01010010, 8'h00,       4'b1010, 0,  {8'd16, 8'd48, 8'd16, 8'd48}};
        vecs[1] = '{8'b01010010, 8'h00,       4'b1010, 1,  {8'd48, 8'd16, 8'd48, 8'd16}};
        vecs[2] = '{8'b01010010, 8'h00,       4'b1010, 9,  {8'd16, 8'd48, 8'd16, 8'd48}};
        vecs[3] = '{8'b11001100, 8'h00,       4'b1111, 8,  {8'd48, 8'd16, 8'd48, 8'd16}};
        vecs[4] = '{8'b11001100, 8'h00,       4'b1111, 11, {8'd48, 8'd16, 8'd48, 8'd16}};
        vecs[5] = '{8'b10000011, 8'b01011100, 4'b1100, 5,  {8'd16, 8'd48, 8'd16, 8'd48}};
        vecs[6] = '{8'b10000011, 8'b01011100, 4'b1100, 10, {8'd16, 8'd48, 8'd16, 8'd48}};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_cod", 32'(cod_o), 32'd0);
        check("reset_sync", 32'(sync), 32'd0);

        // Table-driven words
        for (int i = 0; i < 7; i++) begin
            cur_a = mk_a(vecs[i].a_val, vecs[i].a_flt);
            cur_d = vecs[i].d;
            do_reset(cur_a, cur_d);
            capture_word(-1, cur_a, cur_d);
            w = measure_bit(vecs[i].chk_bit);
            check($sformatf("vec%0d_bit%0d_widths", i, vecs[i].chk_bit), w, vecs[i].exp_w);
            check($sformatf("vec%0d_sync_window", i), sync_stats(), {16'd512, 16'd16});
            check_word($sformatf("vec%0d", i), cur_a, cur_d);
        end

        // Asynchronous reset in the middle of the sync window
        cur_a = 8'b01101001;
        cur_d = 4'b0110;
        do_reset(cur_a, cur_d);
        repeat (SYNC_START + 5) @(negedge clk);
        check("pre_abort_cod", 32'(cod_o), 32'd1);
        check("pre_abort_sync", 32'(sync), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_cod", 32'(cod_o), 32'd0);
        check("abort_sync", 32'(sync), 32'd0);
        #500;
        @(negedge clk);
        last_rise = -1;
        prev_sync = 1'b0;
        reset     = 1'b1;
        capture_word(-1, cur_a, cur_d);
        check("restart_first_cod", 32'(cap_cod[0]), 32'd1);
        check("restart_bit0_widths", measure_bit(0), {8'd48, 8'd16, 8'd48, 8'd16});
        check_word("after_abort", cur_a, cur_d);

        // Random back-to-back words with inputs changed mid-word
        cur_a = 8'($urandom);
        cur_d = 4'($urandom);
        do_reset(cur_a, cur_d);
        for (int k = 0; k < 6; k++) begin
            nxt_a = mk_a(8'($urandom), 8'($urandom & $urandom & $urandom));
            nxt_d = 4'($urandom);
            capture_word(int'($urandom_range(100, 1900)), nxt_a, nxt_d);
            check_word($sformatf("rand%0d", k), cur_a, cur_d);
            cur_a = nxt_a;
            cur_d = nxt_d;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
